// File: rtl/dual_grant_arbiter_pkg.sv
// Shared constants, channel state encoding and index helpers for the dual-grant arbiter.
package dual_grant_pkg;

    localparam int N_REQ = 12;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } ch_state_e;

    // 1-based index to one-hot; 0 or out-of-range indices give an all-zero vector
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec = {N_REQ{1'b0}};
        if ((idx != {IDX_W{1'b0}}) && (idx <= IDX_W'(N_REQ))) begin
            vec[idx - 4'd1] = 1'b1;
        end else begin
            vec = {N_REQ{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/dual_grant_arbiter_if.sv
// Request/grant bundle between the requesters and the dual-grant arbiter.
interface dual_grant_arbiter_if;
    import dual_grant_pkg::*;

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] gnt0_idx;
    logic [IDX_W-1:0] gnt1_idx;
    logic [N_REQ-1:0] gnt_vec;
    logic [1:0]       busy;
    logic [1:0]       timeout;

    modport master (output req, input gnt0_idx, input gnt1_idx, input gnt_vec,
                    input busy, input timeout);
    modport slave  (input req, output gnt0_idx, output gnt1_idx, output gnt_vec,
                    output busy, output timeout);

endinterface

// File: rtl/dual_grant_arbiter_dual_prio_enc.sv
// Combinational encoder giving the highest and second-highest set bits as 1-based indices.
module dual_prio_enc
    import dual_grant_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] first_idx,
    output logic [IDX_W-1:0] second_idx
);

    logic [IDX_W-1:0] first_s;
    logic [IDX_W-1:0] second_s;

    // Scan from the top bit down, keeping the first two hits
    always_comb begin
        first_s  = {IDX_W{1'b0}};
        second_s = {IDX_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i] && (first_s == {IDX_W{1'b0}})) begin
                first_s = IDX_W'(i + 1);
            end else if (vec[i] && (second_s == {IDX_W{1'b0}})) begin
                second_s = IDX_W'(i + 1);
            end else begin
                second_s = second_s;
            end
        end
    end

    assign first_idx  = first_s;
    assign second_idx = second_s;

endmodule

// File: rtl/dual_grant_arbiter.sv
// Two-channel arbiter for 12 requesters: highest eligible request to ch0, next to ch1,
// grants held until release or hold timeout, with one recovery cycle per channel.
module dual_grant_arbiter
    import dual_grant_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    dual_grant_arbiter_if.slave  bus
);

    ch_state_e        state_r     [2];
    logic [IDX_W-1:0] idx_r       [2];
    logic [CNT_W-1:0] cnt_r       [2];
    logic [N_REQ-1:0] mask_r;
    logic [N_REQ-1:0] gnt_vec_r;
    logic [1:0]       busy_r;
    logic [1:0]       timeout_r;

    ch_state_e        nxt_state_s [2];
    logic [IDX_W-1:0] nxt_idx_s   [2];
    logic [CNT_W-1:0] nxt_cnt_s   [2];
    logic [IDX_W-1:0] pick_s      [2];
    logic [1:0]       own_req_s;
    logic [1:0]       to_s;
    logic [N_REQ-1:0] mask_set_s;
    logic [N_REQ-1:0] granted_s;
    logic [N_REQ-1:0] elig_s;
    logic [IDX_W-1:0] first_s;
    logic [IDX_W-1:0] second_s;

    assign granted_s    = idx2onehot(idx_r[0]) | idx2onehot(idx_r[1]);
    assign elig_s       = bus.req & ~mask_r & ~granted_s;
    assign own_req_s[0] = |(bus.req & idx2onehot(idx_r[0]));
    assign own_req_s[1] = |(bus.req & idx2onehot(idx_r[1]));

    dual_prio_enc u_enc (
        .vec        (elig_s),
        .first_idx  (first_s),
        .second_idx (second_s)
    );

    // Route encoder outputs to whichever channels are idle this cycle
    always_comb begin
        pick_s[0] = {IDX_W{1'b0}};
        pick_s[1] = {IDX_W{1'b0}};
        if ((state_r[0] == IDLE) && (state_r[1] == IDLE)) begin
            pick_s[0] = first_s;
            pick_s[1] = second_s;
        end else if (state_r[0] == IDLE) begin
            pick_s[0] = first_s;
        end else if (state_r[1] == IDLE) begin
            pick_s[1] = first_s;
        end else begin
            pick_s[0] = {IDX_W{1'b0}};
            pick_s[1] = {IDX_W{1'b0}};
        end
    end

    // Per-channel next state, owner index, hold count and forced-release detection
    always_comb begin
        mask_set_s = {N_REQ{1'b0}};
        to_s       = 2'b00;
        for (int k = 0; k < 2; k++) begin
            nxt_state_s[k] = state_r[k];
            nxt_idx_s[k]   = idx_r[k];
            nxt_cnt_s[k]   = cnt_r[k];
            case (state_r[k])
                IDLE: begin
                    if (pick_s[k] != {IDX_W{1'b0}}) begin
                        nxt_state_s[k] = GRANT;
                        nxt_idx_s[k]   = pick_s[k];
                        nxt_cnt_s[k]   = 8'd1;
                    end else begin
                        nxt_state_s[k] = IDLE;
                    end
                end
                GRANT: begin
                    if (!own_req_s[k]) begin
                        nxt_state_s[k] = RECOVER;
                        nxt_idx_s[k]   = {IDX_W{1'b0}};
                        nxt_cnt_s[k]   = 8'd0;
                    end else if (cnt_r[k] >= CNT_W'(MAX_HOLD)) begin
                        // Release wins over holding; the owner is masked until it drops req
                        nxt_state_s[k] = RECOVER;
                        nxt_idx_s[k]   = {IDX_W{1'b0}};
                        nxt_cnt_s[k]   = 8'd0;
                        to_s[k]        = 1'b1;
                        mask_set_s     = mask_set_s | idx2onehot(idx_r[k]);
                    end else begin
                        nxt_cnt_s[k]   = cnt_r[k] + 8'd1;
                    end
                end
                RECOVER: begin
                    nxt_state_s[k] = IDLE;
                end
                default: begin
                    nxt_state_s[k] = IDLE;
                    nxt_idx_s[k]   = {IDX_W{1'b0}};
                    nxt_cnt_s[k]   = 8'd0;
                end
            endcase
        end
    end

    // Channel FSMs and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                state_r[k] <= IDLE;
                idx_r[k]   <= {IDX_W{1'b0}};
                cnt_r[k]   <= {CNT_W{1'b0}};
            end
            gnt_vec_r <= {N_REQ{1'b0}};
            busy_r    <= 2'b00;
            timeout_r <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_r[k]   <= nxt_state_s[k];
                idx_r[k]     <= nxt_idx_s[k];
                cnt_r[k]     <= nxt_cnt_s[k];
                busy_r[k]    <= (nxt_state_s[k] == GRANT);
            end
            gnt_vec_r <= idx2onehot(nxt_idx_s[0]) | idx2onehot(nxt_idx_s[1]);
            timeout_r <= to_s;
        end
    end

    // Timeout mask: set on forced release, cleared whenever the requester drops req
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r <= {N_REQ{1'b0}};
        end else begin
            mask_r <= (mask_r & bus.req) | mask_set_s;
        end
    end

    assign bus.gnt0_idx = idx_r[0];
    assign bus.gnt1_idx = idx_r[1];
    assign bus.gnt_vec  = gnt_vec_r;
    assign bus.busy     = busy_r;
    assign bus.timeout  = timeout_r;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Randomized and directed scoreboard bench for dual_grant_arbiter against a queue-based model.
module tb_dual_grant_arbiter;
    import dual_grant_pkg::*;

    localparam int MAX_HOLD = 16;

    typedef struct packed {
        logic [3:0]  i0;
        logic [3:0]  i1;
        logic [11:0] vec;
        logic [1:0]  busy;
        logic [1:0]  to;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    dual_grant_arbiter_if bus();

    dual_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   own[2];
    int   hold[2];
    bit   rec[2];
    bit   banned[12];
    int   run[2];
    int   prev_idx[2];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; hold[k] = 0; rec[k] = 1'b0;
        end
        for (int i = 0; i < 12; i++) banned[i] = 1'b0;
    endfunction

    // One clock of the rule-level model: releases, then free channels pull from a ranked list
    function automatic void model_step(input logic [11:0] r);
        int   cand[$];
        int   nown[2];
        int   nhold[2];
        bit   nrec[2];
        bit   newban[12];
        exp_t e;
        e = '0;
        for (int i = 0; i < 12; i++) newban[i] = 1'b0;
        for (int i = 11; i >= 0; i--)
            if (r[i] && !banned[i] && own[0] != i + 1 && own[1] != i + 1) cand.push_back(i + 1);
        for (int k = 0; k < 2; k++) begin
            nown[k] = own[k]; nhold[k] = hold[k]; nrec[k] = 1'b0;
            if (own[k] != 0) begin
                if (!r[own[k] - 1]) begin
                    nown[k] = 0; nhold[k] = 0; nrec[k] = 1'b1;
                end else if (hold[k] == MAX_HOLD) begin
                    nown[k] = 0; nhold[k] = 0; nrec[k] = 1'b1;
                    e.to[k] = 1'b1; newban[own[k] - 1] = 1'b1;
                end else begin
                    nhold[k] = hold[k] + 1;
                end
            end else if (!rec[k] && cand.size() > 0) begin
                nown[k] = cand.pop_front(); nhold[k] = 1;
            end
        end
        for (int i = 0; i < 12; i++) banned[i] = (banned[i] && r[i]) || newban[i];
        for (int k = 0; k < 2; k++) begin
            own[k] = nown[k]; hold[k] = nhold[k]; rec[k] = nrec[k];
            if (own[k] != 0) begin
                e.vec[own[k] - 1] = 1'b1;
                e.busy[k] = 1'b1;
            end
        end
        e.i0 = 4'(own[0]);
        e.i1 = 4'(own[1]);
        q.push_back(e);
    endfunction

    task automatic cyc(input logic [11:0] r);
        @(negedge clk);
        bus.req = r;
        model_step(r);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        check({name, "_g0"}, 32'(bus.gnt0_idx), 32'd0);
        check({name, "_g1"}, 32'(bus.gnt1_idx), 32'd0);
        check({name, "_vec"}, 32'(bus.gnt_vec), 32'd0);
        check({name, "_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_to"}, 32'(bus.timeout), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        bus.req = 12'h000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops the expected response for each edge and checks structural invariants
    initial begin
        exp_t e;
        prev_idx[0] = 0; prev_idx[1] = 0; run[0] = 0; run[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_g0", 32'(bus.gnt0_idx), 32'(e.i0));
                check("sb_g1", 32'(bus.gnt1_idx), 32'(e.i1));
                check("sb_vec", 32'(bus.gnt_vec), 32'(e.vec));
                check("sb_busy", 32'(bus.busy), 32'(e.busy));
                check("sb_to", 32'(bus.timeout), 32'(e.to));
            end
            check("popcount_le2", 32'($countones(bus.gnt_vec) <= 2), 32'd1);
            check("no_dup_idx", 32'((bus.gnt0_idx == 4'd0) || (bus.gnt0_idx != bus.gnt1_idx)), 32'd1);
            for (int k = 0; k < 2; k++) begin
                int cur;
                cur = (k == 0) ? int'(bus.gnt0_idx) : int'(bus.gnt1_idx);
                run[k] = (cur == 0) ? 0 : ((cur == prev_idx[k]) ? run[k] + 1 : 1);
                prev_idx[k] = cur;
            end
            check("hold_limit", 32'((run[0] <= MAX_HOLD) && (run[1] <= MAX_HOLD)), 32'd1);
        end
    end

    // Stimulus: directed scenarios, then a long biased-random run
    initial begin
        logic [11:0] r;
        bus.req = 12'h000;
        model_reset();
        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        cyc(12'h801); settle();
        check("t1_g0", 32'(bus.gnt0_idx), 32'd12);
        check("t1_g1", 32'(bus.gnt1_idx), 32'd1);
        check("t1_vec", 32'(bus.gnt_vec), 32'h801);
        check("t1_busy", 32'(bus.busy), 32'd3);
        repeat (3) cyc(12'h000);

        cyc(12'h0A8); settle();
        check("t2_g0", 32'(bus.gnt0_idx), 32'd8);
        check("t2_g1", 32'(bus.gnt1_idx), 32'd6);
        cyc(12'h028); settle();
        check("t2_release", 32'(bus.gnt0_idx), 32'd0);
        cyc(12'h028); cyc(12'h028); settle();
        check("t2_regrant", 32'(bus.gnt0_idx), 32'd4);
        repeat (3) cyc(12'h000);

        repeat (16) cyc(12'h080); settle();
        check("t3_held16", 32'(bus.gnt0_idx), 32'd8);
        cyc(12'h080); settle();
        check("t3_timeout", 32'(bus.timeout), 32'd1);
        check("t3_drop", 32'(bus.gnt0_idx), 32'd0);
        repeat (4) cyc(12'h080); settle();
        check("t3_masked", 32'(bus.gnt_vec), 32'd0);
        cyc(12'h000); cyc(12'h080); settle();
        check("t3_regrant", 32'(bus.gnt0_idx), 32'd8);
        repeat (3) cyc(12'h000);

        cyc(12'h0C0); repeat (3) cyc(12'h8C0); settle();
        check("t4_nopreempt", 32'({bus.gnt0_idx, bus.gnt1_idx}), 32'h87);
        repeat (3) cyc(12'h840); settle();
        check("t4_bit11", 32'(bus.gnt0_idx), 32'd12);
        repeat (3) cyc(12'h000);

        cyc(12'h030); settle();
        check("t5_busy", 32'(bus.busy), 32'd3);
        do_reset();
        repeat (4) cyc(12'h000); settle();
        check_zero("t5_after");

        r = 12'h000;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 12; i++)
                if ($urandom_range(0, 15) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 299) == 0) r = 12'h000;
            if (n == 5000) do_reset();
            cyc(r);
        end
        repeat (2) cyc(12'h000);
        settle();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
